// File: rtl/core_rf_wb_arbiter.sv
// rtl/core_rf_wb_arbiter.sv - round-robin arbiter for the shared register-file write port
module core_rf_wb_arbiter #(
    parameter int N_REQ = 3,
    parameter int XLEW  = 64,
    parameter int AW    = 5,
    parameter int CNT_W = 32
) (
    input  logic                       i_wba_clk,
    input  logic                       i_wba_rst_n,
    input  logic [N_REQ-1:0]           i_wba_req_valid,
    output logic [N_REQ-1:0]           o_wba_req_ready,
    input  logic [N_REQ*AW-1:0]        i_wba_req_addr,
    input  logic [N_REQ*XLEW-1:0]      i_wba_req_data,
    input  logic                       i_wba_stall,
    output logic                       o_wba_we3,
    output logic [AW-1:0]              o_wba_a3,
    output logic [XLEW-1:0]            o_wba_wd3,
    output logic [$clog2(N_REQ)-1:0]   o_wba_grant_id,
    output logic [CNT_W-1:0]           o_wba_wr_cnt
);

    localparam int IW = $clog2(N_REQ);

    logic [IW-1:0]   rr_ptr;
    logic            found;
    logic [IW-1:0]   grant_idx;
    logic [IW-1:0]   next_ptr;
    logic [AW-1:0]   sel_addr;
    logic [XLEW-1:0] sel_data;
    logic            xfer;
    int              j;

    // Search upward from rr_ptr with wrap; the first valid requester wins.
    always_comb begin
        found     = 1'b0;
        grant_idx = '0;
        next_ptr  = '0;
        sel_addr  = '0;
        sel_data  = '0;
        j         = 0;
        for (int i = 0; i < N_REQ; i++) begin
            j = int'(rr_ptr) + i;
            if (j >= N_REQ) begin
                j = j - N_REQ;
            end
            if (!found && i_wba_req_valid[j]) begin
                found     = 1'b1;
                grant_idx = IW'(j);
                next_ptr  = (j == N_REQ - 1) ? '0 : IW'(j + 1);
                sel_addr  = i_wba_req_addr[j*AW +: AW];
                sel_data  = i_wba_req_data[j*XLEW +: XLEW];
            end
        end
    end

    assign xfer            = found & ~i_wba_stall & i_wba_rst_n;
    assign o_wba_req_ready = xfer ? (N_REQ'(1) << grant_idx) : '0;

    // Writes to x0 are handshaken and rotate the pointer but never reach the RF.
    always_ff @(posedge i_wba_clk or negedge i_wba_rst_n) begin
        if (!i_wba_rst_n) begin
            o_wba_we3      <= 1'b0;
            o_wba_a3       <= '0;
            o_wba_wd3      <= '0;
            o_wba_grant_id <= '0;
            o_wba_wr_cnt   <= '0;
            rr_ptr         <= '0;
        end else if (xfer) begin
            o_wba_a3       <= sel_addr;
            o_wba_wd3      <= sel_data;
            o_wba_grant_id <= grant_idx;
            o_wba_we3      <= (sel_addr != '0);
            rr_ptr         <= next_ptr;
            if (sel_addr != '0) begin
                o_wba_wr_cnt <= o_wba_wr_cnt + CNT_W'(1);
            end
        end else begin
            o_wba_we3 <= 1'b0;
        end
    end

endmodule

// File: tb/tb_core_rf_wb_arbiter.sv
// tb/tb_core_rf_wb_arbiter.sv - self-checking bench for core_rf_wb_arbiter
module tb_core_rf_wb_arbiter;

    localparam int N     = 3;
    localparam int XLEW  = 64;
    localparam int AW    = 5;
    localparam int CNT_W = 4;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [N-1:0]    valid = '0;
    logic [AW-1:0]   addr [N];
    logic [XLEW-1:0] data [N];
    logic            stall = 1'b0;

    logic [N-1:0]      ready;
    logic [N*AW-1:0]   req_addr;
    logic [N*XLEW-1:0] req_data;
    logic              we3;
    logic [AW-1:0]     a3;
    logic [XLEW-1:0]   wd3;
    logic [1:0]        gid;
    logic [CNT_W-1:0]  cnt;

    int checks = 0;
    int errors = 0;
    bit chk_en = 0;

    assign req_addr = {addr[2], addr[1], addr[0]};
    assign req_data = {data[2], data[1], data[0]};

    core_rf_wb_arbiter #(.N_REQ(N), .XLEW(XLEW), .AW(AW), .CNT_W(CNT_W)) dut (
        .i_wba_clk(clk), .i_wba_rst_n(rst_n),
        .i_wba_req_valid(valid), .o_wba_req_ready(ready),
        .i_wba_req_addr(req_addr), .i_wba_req_data(req_data),
        .i_wba_stall(stall),
        .o_wba_we3(we3), .o_wba_a3(a3), .o_wba_wd3(wd3),
        .o_wba_grant_id(gid), .o_wba_wr_cnt(cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: state as the spec describes it, grant from modular search.
    int              m_ptr;
    bit              m_we;
    logic [AW-1:0]   m_a3;
    logic [XLEW-1:0] m_wd3;
    int              m_gid;
    int              m_cnt;

    function automatic int model_grant();
        if (!rst_n || stall) return -1;
        for (int i = 0; i < N; i++) begin
            if (valid[(m_ptr + i) % N]) return (m_ptr + i) % N;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_ptr = 0; m_we = 0; m_a3 = '0; m_wd3 = '0; m_gid = 0; m_cnt = 0;
    endtask

    always @(negedge rst_n) model_reset();

    always @(posedge clk) begin
        int g;
        if (!rst_n) begin
            model_reset();
        end else begin
            g = model_grant();
            if (g >= 0) begin
                m_a3  = addr[g];
                m_wd3 = data[g];
                m_gid = g;
                m_we  = (addr[g] != 0);
                m_ptr = (g + 1) % N;
                if (m_we) m_cnt = (m_cnt + 1) % (1 << CNT_W);
            end else begin
                m_we = 0;
            end
        end
    end

    always @(negedge clk) begin
        int g;
        logic [N-1:0] exp_ready;
        if (chk_en) begin
            g = model_grant();
            exp_ready = (g >= 0) ? (N'(1) << g) : '0;
            check("m_ready", 64'(ready), 64'(exp_ready));
            check("m_we3", 64'(we3), 64'(m_we));
            check("m_a3", 64'(a3), 64'(m_a3));
            check("m_wd3", wd3, m_wd3);
            check("m_gid", 64'(gid), 64'(m_gid));
            check("m_cnt", 64'(cnt), 64'(m_cnt));
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        valid = '0;
        stall = 0;
        @(posedge clk);
        #1 rst_n = 0;
        cyc();
        rst_n = 1;
    endtask

    initial begin
        for (int i = 0; i < N; i++) begin
            addr[i] = '0;
            data[i] = '0;
        end
        valid = '1;
        cyc();
        cyc();
        chk_en = 1;
        // Reset with all valids held high
        #1;
        check("rst_ready", 64'(ready), 64'h0);
        check("rst_we3", 64'(we3), 64'h0);
        check("rst_a3", 64'(a3), 64'h0);
        check("rst_wd3", wd3, 64'h0);
        check("rst_cnt", 64'(cnt), 64'h0);
        valid = '0;
        rst_n = 1;

        // Single request
        cyc();
        valid = 3'b001; addr[0] = 5'd5; data[0] = 64'hDEAD_BEEF;
        #1 check("single_ready", 64'(ready), 64'b001);
        cyc();
        valid = '0;
        check("single_we3", 64'(we3), 64'h1);
        check("single_a3", 64'(a3), 64'd5);
        check("single_wd3", wd3, 64'hDEAD_BEEF);
        check("single_gid", 64'(gid), 64'd0);
        check("single_cnt", 64'(cnt), 64'd1);
        cyc();
        check("single_we3_off", 64'(we3), 64'h0);

        // Round-robin with all requesters valid
        do_reset();
        for (int i = 0; i < N; i++) begin
            addr[i] = AW'(i + 1);
            data[i] = 64'h100 + 64'(i);
        end
        valid = 3'b111;
        for (int k = 0; k < 6; k++) begin
            cyc();
            check("rr_gid", 64'(gid), 64'(k % 3));
            check("rr_we3", 64'(we3), 64'h1);
        end
        valid = '0;
        check("rr_cnt", 64'(cnt), 64'd6);

        // x0 write
        do_reset();
        valid = 3'b010; addr[1] = 5'd0; data[1] = 64'h1234;
        #1 check("x0_ready", 64'(ready), 64'b010);
        cyc();
        valid = '0;
        check("x0_we3", 64'(we3), 64'h0);
        check("x0_cnt", 64'(cnt), 64'h0);
        addr[1] = 5'd4;
        valid = 3'b111;
        #1 check("x0_next_ready", 64'(ready), 64'b100);
        cyc();
        valid = '0;
        check("x0_next_gid", 64'(gid), 64'd2);

        // Stall
        do_reset();
        addr[0] = 5'd6; addr[1] = 5'd7;
        valid = 3'b011;
        cyc();
        stall = 1;
        #1 check("stall_ready", 64'(ready), 64'h0);
        check("stall_prev_we3", 64'(we3), 64'h1);
        for (int k = 0; k < 3; k++) begin
            cyc();
            check("stall_we3", 64'(we3), 64'h0);
        end
        stall = 0;
        #1 check("unstall_ready", 64'(ready), 64'b010);
        cyc();
        valid = '0;
        check("unstall_gid", 64'(gid), 64'd1);

        // Counter wrap at 4 bits
        do_reset();
        addr[0] = 5'd7;
        valid = 3'b001;
        for (int k = 1; k <= 17; k++) begin
            cyc();
            if (k == 15) check("wrap_15", 64'(cnt), 64'd15);
            if (k == 16) check("wrap_16", 64'(cnt), 64'd0);
            if (k == 17) check("wrap_17", 64'(cnt), 64'd1);
        end
        valid = '0;

        // Asynchronous reset while a write is on the port
        cyc();
        addr[0] = 5'd9; data[0] = 64'h55;
        valid = 3'b001;
        cyc();
        check("async_pre_we3", 64'(we3), 64'h1);
        #1 rst_n = 0;
        #1;
        check("async_we3", 64'(we3), 64'h0);
        check("async_a3", 64'(a3), 64'h0);
        check("async_cnt", 64'(cnt), 64'h0);
        check("async_ready", 64'(ready), 64'h0);
        cyc();
        check("async_hold_ready", 64'(ready), 64'h0);
        valid = '0;
        rst_n = 1;
        cyc();
        cyc();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
